mux_arb_rr: RTL and testbench
=============================

MUX_ARB_RR -- requirements
Module: mux_arb_rr

Interface
REQ-001 Parameter N, default 64: data width per channel, N >= 1.
REQ-002 Parameter M, default 4: channel count, M >= 2.
REQ-003 Parameter SW, default $clog2(M): select/index width; derived, not overridden.
REQ-004 i_clk  input  1: single clock; all state updates on rising edge.
REQ-005 i_rst_n  input  1: reset, asynchronous, active-low.
REQ-006 i_in  input  M x N: channel data, channel k at slice k.
REQ-007 i_valid  input  M: per-channel request.
REQ-008 o_ready  output  M: per-channel accept strobe.
REQ-009 i_mode  input  1: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-010 o_out  output  N: registered selected data.
REQ-011 o_valid  output  1: o_out holds an undelivered word.
REQ-012 i_ready  input  1: downstream accepts o_out this cycle.
REQ-013 o_sel  output  SW: index of the channel whose word is in o_out.

Function
REQ-014 Output register "free" when o_valid=0 or (o_valid=1 and i_ready=1).
REQ-015 When free and any i_valid set, grant exactly one channel g; o_ready[g]=1, all other o_ready bits 0; o_ready all-zero when not free or no request.
REQ-016 o_ready combinational from i_valid, i_mode, pointer, o_valid, i_ready; no combinational path from i_in.
REQ-017 On grant, next edge loads o_out=i_in[g], o_sel=g, o_valid=1; latency input-to-output 1 cycle.
REQ-018 Free and no request: next edge o_valid=0; o_out and o_sel hold previous values.
REQ-019 Not free (o_valid=1, i_ready=0): o_out, o_sel, o_valid hold; no grant.
REQ-020 Simultaneous drain and grant (o_valid=1, i_ready=1, request present): new word loads same edge; full throughput of one word per cycle.
REQ-021 Round-robin: pointer p (SW bits) names highest-priority channel; search p, p+1, ... wrapping modulo M; first requesting channel wins.
REQ-022 After a round-robin grant to g, p <= (g+1) mod M; g = M-1 wraps p to 0; M non-power-of-two wraps at M, never to unused indices.
REQ-023 Fixed-priority mode: lowest requesting index wins; p not updated.
REQ-024 i_mode change takes effect in the same cycle's arbitration; p retains its value across mode changes.
REQ-025 No grant cycle leaves p unchanged.
REQ-026 Single requester always granted when free, regardless of p or mode.

Reset
REQ-027 i_rst_n low asynchronously forces o_valid=0, o_out=0, o_sel=0, p=0; o_ready=0 while reset asserted.
REQ-028 Reset mid-transfer discards the held word; no grant on the first edge after deassertion unless free and requested (normal rules).

Structure
REQ-029 Package mux_pkg holds mode enum (MODE_RR=0, MODE_FIXED=1) and default N/M constants.
REQ-030 One combinational sub-module rr_pick (M-bit request, SW-bit start index -> one-hot grant, SW-bit index, any-flag); fixed mode uses start index 0.
REQ-031 Implementation is purely synchronous except the async reset; no latches.

Verification
REQ-032 M=4, RR, i_valid=4'b1111 held, i_ready=1: grants 0,1,2,3,0; o_sel follows one cycle later; o_valid continuously 1.
REQ-033 RR, p=3, i_valid=4'b1001: grant 3, then p=0 -> grant 0; i_valid=4'b0010 only -> grant 1 from any p.
REQ-034 Backpressure: o_valid=1, i_ready=0 for 3 cycles with i_valid=4'b0100: o_ready=0, o_out/o_sel stable; i_ready=1 -> channel 2 loads same edge.
REQ-035 Fixed mode, i_valid=4'b1100 held: channel 2 granted every cycle, p unchanged; switch to RR -> next grant from stored p.
REQ-036 M=3: grant to channel 2 wraps p to 0, never 3; i_in[k]=64'hA5A5_0000_0000_000k checked at o_out.
REQ-037 Assert i_rst_n=0 mid-stream while o_valid=1: o_valid=0, o_out=0, o_sel=0 immediately; first post-reset grant is lowest requester (p=0).

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and default sizing for the round-robin / fixed-priority channel mux.
package mux_pkg;

   localparam int unsigned DEF_N = 64;
   localparam int unsigned DEF_M = 4;

   typedef enum logic {
      MODE_RR    = 1'b0,
      MODE_FIXED = 1'b1
   } mode_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first request found at or after start, wrapping at M.
module rr_pick #(
   parameter  int unsigned M  = 4,
   localparam int unsigned SW = $clog2(M)
) (
   input  logic [M-1:0]  req,
   input  logic [SW-1:0] start,
   output logic [M-1:0]  grant,
   output logic [SW-1:0] idx,
   output logic          any
);

   always_comb begin
      int unsigned c;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      c     = 0;
      for (int unsigned i = 0; i < M; i++) begin
         // wrap at M, not at 2**SW, so unused indices are never visited
         c = (32'(start) + i) % M;
         if (!any && req[SW'(c)]) begin
            any              = 1'b1;
            grant[SW'(c)]    = 1'b1;
            idx              = SW'(c);
         end
      end
   end

endmodule

// File: rtl/mux_arb_rr.sv
// M-channel arbitrated mux with a one-word registered output stage and valid/ready handshakes.
module mux_arb_rr
   import mux_pkg::*;
#(
   parameter  int unsigned N  = DEF_N,
   parameter  int unsigned M  = DEF_M,
   localparam int unsigned SW = $clog2(M)
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic [M*N-1:0] i_in,
   input  logic [M-1:0]   i_valid,
   output logic [M-1:0]   o_ready,
   input  logic           i_mode,
   output logic [N-1:0]   o_out,
   output logic           o_valid,
   input  logic           i_ready,
   output logic [SW-1:0]  o_sel
);

   logic [SW-1:0] ptr;
   logic [SW-1:0] start_c;
   logic [SW-1:0] pick_idx;
   logic [SW-1:0] ptr_nxt_c;
   logic [M-1:0]  pick_grant;
   logic          pick_any;
   logic          free_c;
   logic          take_c;
   mode_e         mode_c;
   logic [N-1:0]  chan [M];

   for (genvar k = 0; k < M; k++) begin : g_chan
      assign chan[k] = i_in[k*N +: N];
   end

   assign mode_c  = mode_e'(i_mode);
   assign free_c  = !o_valid || i_ready;
   assign start_c = (mode_c == MODE_FIXED) ? '0 : ptr;

   rr_pick #(.M(M)) u_pick (
      .req   (i_valid),
      .start (start_c),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // Grant strobe depends only on request/handshake state, never on channel data.
   assign take_c    = free_c && pick_any;
   assign o_ready   = (take_c && i_rst_n) ? pick_grant : '0;
   assign ptr_nxt_c = (pick_idx == SW'(M-1)) ? '0 : pick_idx + SW'(1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid <= 1'b0;
         o_out   <= '0;
         o_sel   <= '0;
         ptr     <= '0;
      end else if (free_c) begin
         o_valid <= pick_any;
         if (pick_any) begin
            o_out <= chan[pick_idx];
            o_sel <= pick_idx;
            if (mode_c == MODE_RR) begin
               ptr <= ptr_nxt_c;
            end
         end
      end
   end

endmodule

// File: tb/tb_mux_arb_rr.sv
// Directed bench for mux_arb_rr: a 4-channel and a 3-channel instance checked against hand-derived grants.
module tb_mux_arb_rr;

   localparam int unsigned N = 64;

   logic           clk;
   logic           rst_n;

   logic [4*N-1:0] a_in;
   logic [3:0]     a_valid, a_o_ready;
   logic           a_mode, a_ready, a_o_valid;
   logic [N-1:0]   a_o_out;
   logic [1:0]     a_o_sel;

   logic [3*N-1:0] b_in;
   logic [2:0]     b_valid, b_o_ready;
   logic           b_mode, b_ready, b_o_valid;
   logic [N-1:0]   b_o_out;
   logic [1:0]     b_o_sel;

   int n_checks = 0;
   int n_pass   = 0;

   mux_arb_rr #(.N(N), .M(4)) u_dut4 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_in    (a_in),
      .i_valid (a_valid),
      .o_ready (a_o_ready),
      .i_mode  (a_mode),
      .o_out   (a_o_out),
      .o_valid (a_o_valid),
      .i_ready (a_ready),
      .o_sel   (a_o_sel)
   );

   mux_arb_rr #(.N(N), .M(3)) u_dut3 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_in    (b_in),
      .i_valid (b_valid),
      .o_ready (b_o_ready),
      .i_mode  (b_mode),
      .o_out   (b_o_out),
      .o_valid (b_o_valid),
      .i_ready (b_ready),
      .o_sel   (b_o_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [N-1:0] data(input int k);
      return {48'hA5A5_0000_0000, 16'(k)};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // Drive one cycle on the 4-channel DUT: check the grant strobe, then the registered result.
   task automatic beat_a(input string tag, input logic [3:0] v, input logic m, input logic r,
                         input logic [3:0] e_rdy, input logic e_vld, input int e_sel);
      a_valid = v; a_mode = m; a_ready = r;
      #1;
      check({tag, "/rdy"}, 64'(a_o_ready), 64'(e_rdy));
      @(posedge clk); #1;
      check({tag, "/vld"}, 64'(a_o_valid), 64'(e_vld));
      check({tag, "/sel"}, 64'(a_o_sel), 64'(e_sel));
      check({tag, "/out"}, a_o_out, data(e_sel));
   endtask

   task automatic beat_b(input string tag, input logic [2:0] v,
                         input logic [2:0] e_rdy, input int e_sel);
      b_valid = v; b_mode = 1'b0; b_ready = 1'b1;
      #1;
      check({tag, "/rdy"}, 64'(b_o_ready), 64'(e_rdy));
      @(posedge clk); #1;
      check({tag, "/vld"}, 64'(b_o_valid), 64'(1));
      check({tag, "/sel"}, 64'(b_o_sel), 64'(e_sel));
      check({tag, "/out"}, b_o_out, data(e_sel));
   endtask

   initial begin
      rst_n   = 1'b0;
      a_valid = 4'b1111; a_mode = 1'b0; a_ready = 1'b1;
      b_valid = 3'b000;  b_mode = 1'b0; b_ready = 1'b1;
      for (int k = 0; k < 4; k++) a_in[k*N +: N] = data(k);
      for (int k = 0; k < 3; k++) b_in[k*N +: N] = data(k);

      // reset state, requests pending
      #2;
      check("rst/vld", 64'(a_o_valid), 64'(0));
      check("rst/out", a_o_out, 64'(0));
      check("rst/sel", 64'(a_o_sel), 64'(0));
      check("rst/rdy", 64'(a_o_ready), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;

      // all requesting, round-robin sweep 0,1,2,3,0 at full throughput
      beat_a("rr0", 4'b1111, 1'b0, 1'b1, 4'b0001, 1'b1, 0);
      beat_a("rr1", 4'b1111, 1'b0, 1'b1, 4'b0010, 1'b1, 1);
      beat_a("rr2", 4'b1111, 1'b0, 1'b1, 4'b0100, 1'b1, 2);
      beat_a("rr3", 4'b1111, 1'b0, 1'b1, 4'b1000, 1'b1, 3);
      beat_a("rr4", 4'b1111, 1'b0, 1'b1, 4'b0001, 1'b1, 0);

      // walk p to 3, then 1001: grant 3, wrap, grant 0; single requester 1
      beat_a("walk1", 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b1, 1);
      beat_a("walk2", 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b1, 2);
      beat_a("p3g3",  4'b1001, 1'b0, 1'b1, 4'b1000, 1'b1, 3);
      beat_a("p0g0",  4'b1001, 1'b0, 1'b1, 4'b0001, 1'b1, 0);
      beat_a("solo1", 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b1, 1);

      // backpressure holds word 1, then channel 2 loads on release
      for (int i = 0; i < 3; i++) beat_a("bp", 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b1, 1);
      beat_a("bprel", 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b1, 2);

      // fixed priority leaves p at 3; back in RR the stored p picks 3
      for (int i = 0; i < 3; i++) beat_a("fix", 4'b1100, 1'b1, 1'b1, 4'b0100, 1'b1, 2);
      beat_a("fix2rr", 4'b1100, 1'b0, 1'b1, 4'b1000, 1'b1, 3);

      // drained with no request: valid drops, data and index hold
      beat_a("idle", 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 3);

      // mid-stream reset: p had wrapped to 0, streams 0 then 1 leaving p=2
      beat_a("ms0", 4'b1111, 1'b0, 1'b1, 4'b0001, 1'b1, 0);
      beat_a("ms1", 4'b1111, 1'b0, 1'b1, 4'b0010, 1'b1, 1);
      rst_n = 1'b0;
      #1;
      check("mrst/vld", 64'(a_o_valid), 64'(0));
      check("mrst/out", a_o_out, 64'(0));
      check("mrst/sel", 64'(a_o_sel), 64'(0));
      check("mrst/rdy", 64'(a_o_ready), 64'(0));
      #1;
      rst_n = 1'b1;
      beat_a("post", 4'b1110, 1'b0, 1'b1, 4'b0010, 1'b1, 1);

      // three channels: wrap after channel 2 lands on 0
      beat_b("m3_0", 3'b111, 3'b001, 0);
      beat_b("m3_1", 3'b111, 3'b010, 1);
      beat_b("m3_2", 3'b111, 3'b100, 2);
      beat_b("m3_w", 3'b111, 3'b001, 0);
      beat_b("m3_s", 3'b110, 3'b010, 1);
      beat_b("m3_3", 3'b101, 3'b100, 2);
      beat_b("m3_x", 3'b011, 3'b001, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
